// File: rtl/pe_pkg.sv
// Shared definitions for the PE store sequencer: default widths and FSM states.
package pe_pkg;

  localparam int A_DEF = 7;
  localparam int W_DEF = 16;
  localparam int L_DEF = A_DEF + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_K  = 3'd1,
    LOAD_N  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/pe_window_counter.sv
// Base/tap counter pair for a 1-D strided sliding window. The tap walks
// 0..klen-1 inside a window; at the last tap the base advances by stride.
// pass_end flags the step after which no further full window fits.
module pe_window_counter #(
  parameter int A = 7,
  parameter int L = A + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         step,
  input  logic [L-1:0] klen,
  input  logic [L-1:0] nlen,
  input  logic [L-1:0] stride,
  output logic [A-1:0] kaddr,
  output logic [A-1:0] naddr,
  output logic         first_tap,
  output logic         last_tap,
  output logic         pass_end
);

  localparam logic [L-1:0] ONE_L = {{(L-1){1'b0}}, 1'b1};

  logic [L-1:0] base_r;
  logic [L-1:0] tap_r;
  logic [L:0]   next_base_s;
  logic [L:0]   next_end_s;

  // Read addresses: neuron address is base+tap modulo the store depth.
  assign kaddr = tap_r[A-1:0];
  assign naddr = base_r[A-1:0] + tap_r[A-1:0];

  // Window position flags and the one-bit-wider end-of-pass compare.
  always_comb begin
    next_base_s = {1'b0, base_r} + {1'b0, stride};
    next_end_s  = next_base_s + {1'b0, klen};
    first_tap   = (tap_r == {L{1'b0}});
    last_tap    = (tap_r == (klen - ONE_L));
    if (last_tap) begin
      pass_end = (next_end_s > {1'b0, nlen});
    end else begin
      pass_end = 1'b0;
    end
  end

  // Counter state: cleared on init, advanced on step, frozen otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r <= {L{1'b0}};
      tap_r  <= {L{1'b0}};
    end else if (init) begin
      base_r <= {L{1'b0}};
      tap_r  <= {L{1'b0}};
    end else if (step) begin
      if (last_tap) begin
        tap_r  <= {L{1'b0}};
        base_r <= next_base_s[L-1:0];
      end else begin
        tap_r  <= tap_r + ONE_L;
      end
    end
  end

endmodule

// File: rtl/pe_store_sequencer.sv
// Per-PE sequencer: loads kernel then neuron words into the local stores,
// then sweeps read addresses for a strided 1-D convolution. All outputs
// are registered; each is computed one cycle ahead in a *_s signal.
module pe_store_sequencer
  import pe_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int W = W_DEF,
  parameter int L = A + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [L-1:0] cfg_klen,
  input  logic [L-1:0] cfg_nlen,
  input  logic [L-1:0] cfg_stride,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         hold,
  output logic [A-1:0] kernelAddress,
  output logic [A-1:0] neuronAddress,
  output logic         kernelWrite,
  output logic         neuronWrite,
  output logic [W-1:0] writeData,
  output logic         mac_en,
  output logic         acc_clear,
  output logic         win_done,
  output logic         busy,
  output logic         done,
  output logic         cfg_err
);

  localparam logic [L-1:0] ONE_L = {{(L-1){1'b0}}, 1'b1};

  state_t       state_r, state_s;
  logic [L-1:0] klen_r, klen_s;
  logic [L-1:0] nlen_r, nlen_s;
  logic [L-1:0] stride_r, stride_s;
  logic [L-1:0] cnt_r, cnt_s;

  logic         accept_s;
  logic         wc_init_s, wc_step_s;
  logic [A-1:0] wc_kaddr_s, wc_naddr_s;
  logic         wc_first_s, wc_last_s, wc_end_s;

  logic         in_ready_s, kwr_s, nwr_s, mac_s, clr_s, wd_s;
  logic         busy_s, done_s, err_s;
  logic [A-1:0] kaddr_s, naddr_s;
  logic [W-1:0] wdata_s;

  pe_window_counter #(.A(A), .L(L)) u_win (
    .clk       (CLK),
    .rst       (RST),
    .init      (wc_init_s),
    .step      (wc_step_s),
    .klen      (klen_r),
    .nlen      (nlen_r),
    .stride    (stride_r),
    .kaddr     (wc_kaddr_s),
    .naddr     (wc_naddr_s),
    .first_tap (wc_first_s),
    .last_tap  (wc_last_s),
    .pass_end  (wc_end_s)
  );

  // Next state, latched config and next values of every registered output.
  always_comb begin
    state_s   = state_r;
    klen_s    = klen_r;
    nlen_s    = nlen_r;
    stride_s  = stride_r;
    cnt_s     = cnt_r;
    wc_init_s = 1'b0;
    wc_step_s = 1'b0;
    kaddr_s   = kernelAddress;
    naddr_s   = neuronAddress;
    wdata_s   = writeData;
    kwr_s     = 1'b0;
    nwr_s     = 1'b0;
    mac_s     = 1'b0;
    clr_s     = 1'b0;
    wd_s      = 1'b0;
    err_s     = 1'b0;
    accept_s  = in_valid && in_ready;

    case (state_r)
      IDLE: begin
        if (start) begin
          klen_s   = cfg_klen;
          nlen_s   = cfg_nlen;
          stride_s = cfg_stride;
          if ((cfg_klen == {L{1'b0}}) || (cfg_stride == {L{1'b0}}) ||
              (cfg_klen > cfg_nlen)) begin
            err_s = 1'b1;
          end else begin
            state_s = LOAD_K;
            cnt_s   = {L{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_K: begin
        if (accept_s) begin
          kwr_s   = 1'b1;
          kaddr_s = cnt_r[A-1:0];
          wdata_s = in_data;
          if (cnt_r == (klen_r - ONE_L)) begin
            cnt_s   = {L{1'b0}};
            state_s = LOAD_N;
          end else begin
            cnt_s = cnt_r + ONE_L;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      LOAD_N: begin
        if (accept_s) begin
          nwr_s   = 1'b1;
          naddr_s = cnt_r[A-1:0];
          wdata_s = in_data;
          if (cnt_r == (nlen_r - ONE_L)) begin
            cnt_s     = {L{1'b0}};
            wc_init_s = 1'b1;
            state_s   = COMPUTE;
          end else begin
            cnt_s = cnt_r + ONE_L;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      COMPUTE: begin
        if (!hold) begin
          mac_s     = 1'b1;
          kaddr_s   = wc_kaddr_s;
          naddr_s   = wc_naddr_s;
          clr_s     = wc_first_s;
          wd_s      = wc_last_s;
          wc_step_s = 1'b1;
          if (wc_end_s) begin
            state_s = DONE;
          end else begin
            state_s = COMPUTE;
          end
        end else begin
          state_s = COMPUTE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    in_ready_s = (state_s == LOAD_K) || (state_s == LOAD_N);
    busy_s     = (state_s != IDLE);
    done_s     = (state_s == DONE);
  end

  // State, configuration and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      klen_r        <= {L{1'b0}};
      nlen_r        <= {L{1'b0}};
      stride_r      <= {L{1'b0}};
      cnt_r         <= {L{1'b0}};
      in_ready      <= 1'b0;
      kernelAddress <= {A{1'b0}};
      neuronAddress <= {A{1'b0}};
      kernelWrite   <= 1'b0;
      neuronWrite   <= 1'b0;
      writeData     <= {W{1'b0}};
      mac_en        <= 1'b0;
      acc_clear     <= 1'b0;
      win_done      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state_r       <= state_s;
      klen_r        <= klen_s;
      nlen_r        <= nlen_s;
      stride_r      <= stride_s;
      cnt_r         <= cnt_s;
      in_ready      <= in_ready_s;
      kernelAddress <= kaddr_s;
      neuronAddress <= naddr_s;
      kernelWrite   <= kwr_s;
      neuronWrite   <= nwr_s;
      writeData     <= wdata_s;
      mac_en        <= mac_s;
      acc_clear     <= clr_s;
      win_done      <= wd_s;
      busy          <= busy_s;
      done          <= done_s;
      cfg_err       <= err_s;
    end
  end

endmodule

// File: tb/tb_pe_store_sequencer.sv
// Randomised scoreboard bench for pe_store_sequencer.
module tb_pe_store_sequencer;

  localparam int A = 7;
  localparam int W = 16;
  localparam int L = A + 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [L-1:0] cfg_klen = '0, cfg_nlen = '0, cfg_stride = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         hold = 1'b0;
  logic [A-1:0] kernelAddress, neuronAddress;
  logic         kernelWrite, neuronWrite;
  logic [W-1:0] writeData;
  logic         mac_en, acc_clear, win_done, busy, done, cfg_err;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic hold_prev = 1'b0;

  // expected kernel/neuron writes: addr<<16 | data ; taps: clr<<15 | wd<<14 | kaddr<<7 | naddr
  logic [31:0] kq[$];
  logic [31:0] nq[$];
  logic [31:0] mq[$];

  pe_store_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start),
    .cfg_klen(cfg_klen), .cfg_nlen(cfg_nlen), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .hold(hold),
    .kernelAddress(kernelAddress), .neuronAddress(neuronAddress),
    .kernelWrite(kernelWrite), .neuronWrite(neuronWrite), .writeData(writeData),
    .mac_en(mac_en), .acc_clear(acc_clear), .win_done(win_done),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_outs();
    check("rst_addr", 32'({kernelAddress, neuronAddress}), 32'd0);
    check("rst_wdata", 32'(writeData), 32'd0);
    check("rst_ctl", 32'({in_ready, kernelWrite, neuronWrite, mac_en, acc_clear,
                          win_done, done, cfg_err}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (kernelWrite) begin
      check("kwr_expected", 32'(kq.size() > 0), 32'd1);
      if (kq.size() > 0) begin
        e = kq.pop_front();
        check("kwr_addr", 32'(kernelAddress), 32'(e[22:16]));
        check("kwr_data", 32'(writeData), 32'(e[15:0]));
      end
    end
    if (neuronWrite) begin
      check("nwr_expected", 32'(nq.size() > 0), 32'd1);
      if (nq.size() > 0) begin
        e = nq.pop_front();
        check("nwr_addr", 32'(neuronAddress), 32'(e[22:16]));
        check("nwr_data", 32'(writeData), 32'(e[15:0]));
      end
    end
    if (mac_en) begin
      check("mac_not_in_hold", 32'(hold_prev), 32'd0);
      check("mac_expected", 32'(mq.size() > 0), 32'd1);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        check("mac_kaddr", 32'(kernelAddress), 32'(e[13:7]));
        check("mac_naddr", 32'(neuronAddress), 32'(e[6:0]));
        check("mac_flags", 32'({acc_clear, win_done}), 32'(e[15:14]));
      end
    end else if (acc_clear || win_done) begin
      check("flags_without_mac", 32'({acc_clear, win_done}), 32'd0);
    end
    if (done) check("taps_left_at_done", 32'(mq.size()), 32'd0);
    if (cfg_err) err_seen++;
    hold_prev = hold;
  end

  task automatic run_job(input int kl, input int nl, input int st, input int vmode,
                         input int hold_pct, input bit stray, input int abort_n);
    logic [W-1:0] w[$];
    bit legal, acc, aborted, got, stray_done;
    int idx, cyc;
    legal = (kl != 0) && (st != 0) && (kl <= nl);
    aborted = 1'b0;
    stray_done = 1'b0;
    if (legal) begin
      for (int i = 0; i < kl + nl; i++) w.push_back(W'($urandom));
      for (int i = 0; i < kl; i++) kq.push_back((32'(i) << 16) | 32'(w[i]));
      for (int i = 0; i < nl; i++) nq.push_back((32'(i) << 16) | 32'(w[kl + i]));
      for (int b = 0; b + kl <= nl; b += st)
        for (int t = 0; t < kl; t++)
          mq.push_back((32'(t == 0) << 15) | (32'(t == kl - 1) << 14) |
                       (32'(t) << 7) | 32'(b + t));
    end else begin
      exp_err++;
    end

    @(posedge CLK); #1;
    start = 1'b1;
    cfg_klen = kl[L-1:0]; cfg_nlen = nl[L-1:0]; cfg_stride = st[L-1:0];
    @(posedge CLK); #1;
    start = 1'b0;
    cfg_klen = L'($urandom); cfg_nlen = L'($urandom); cfg_stride = L'($urandom);

    if (!legal) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        check("illegal_busy", 32'(busy), 32'd0);
      end
      check("cfg_err_count", 32'(err_seen), 32'(exp_err));
      return;
    end

    idx = 0; cyc = 0;
    while (idx < kl + nl && cyc < 4000) begin
      in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : ($urandom_range(1) == 1);
      in_data = w[idx];
      hold = ($urandom_range(99) < hold_pct);
      if (stray && !stray_done && idx == 2) begin
        start = 1'b1; cfg_klen = 8'd1; cfg_nlen = 8'd1; cfg_stride = 8'd1;
        stray_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      acc = in_valid && in_ready;
      @(posedge CLK); #1;
      if (acc) idx++;
      cyc++;
      if (abort_n >= 0 && idx == kl + abort_n) begin
        RST = 1'b1;
        in_valid = 1'b0; hold = 1'b0; start = 1'b0;
        #1;
        check_reset_outs();
        kq.delete(); nq.delete(); mq.delete();
        @(negedge CLK);
        RST = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (aborted) return;
    check("load_complete", 32'(idx), 32'(kl + nl));

    got = 1'b0; cyc = 0;
    while (!got && cyc < 4000) begin
      hold = ($urandom_range(99) < hold_pct);
      @(negedge CLK);
      if (done) got = 1'b1;
      @(posedge CLK); #1;
      cyc++;
    end
    hold = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    @(negedge CLK);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("kq_left", 32'(kq.size()), 32'd0);
    check("nq_left", 32'(nq.size()), 32'd0);
    check("mq_left", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    int kl, nl, st;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs();
    @(negedge CLK);
    RST = 1'b0;

    run_job(3, 8, 1, 0, 0, 1'b0, -1);
    run_job(3, 8, 2, 0, 0, 1'b0, -1);
    run_job(1, 4, 3, 0, 0, 1'b0, -1);
    run_job(5, 4, 1, 0, 0, 1'b0, -1);
    run_job(3, 8, 0, 0, 0, 1'b0, -1);
    run_job(0, 4, 1, 0, 0, 1'b0, -1);
    run_job(3, 8, 1, 1, 30, 1'b1, -1);
    run_job(3, 8, 1, 0, 0, 1'b0, 2);
    run_job(3, 8, 1, 0, 0, 1'b0, -1);
    run_job(4, 4, 2, 2, 20, 1'b0, -1);
    run_job(128, 128, 1, 2, 20, 1'b0, -1);
    run_job(2, 128, 200, 0, 10, 1'b0, -1);

    for (int j = 0; j < 10; j++) begin
      kl = $urandom_range(16, 1);
      nl = $urandom_range(40, kl);
      st = $urandom_range(8, 1);
      run_job(kl, nl, st, 2, 25, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_store_sequencer.md
Name: pe_store_sequencer

Overview:
- Per-PE sequencer for the kernel and neuron local stores.
- Phase 1 (load): accepts a stream of kernel words, then neuron words, and writes each into its store at consecutive addresses.
- Phase 2 (compute): drives read addresses for a 1-D strided sliding-window convolution and emits MAC-enable, accumulator-clear and window-done strobes to the PE datapath.
- Sits between the PE input stream and the two local store RAMs.

Parameters:
- A, 7: local store address width; store depth is 2^A words.
- W, 16: data word width.
- L, A+1 (derived): length field width, covers 1..2^A.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches the cfg_* inputs; honoured only in IDLE.
- cfg_klen  in  L  kernel length in words.
- cfg_nlen  in  L  neuron length in words.
- cfg_stride  in  L  window stride.
- in_valid  in  1  input word valid.
- in_ready  out  1  sequencer accepts the input word.
- in_data  in  W  input word (kernel words first, then neuron words).
- hold  in  1  stall request from the datapath during compute.
- kernelAddress  out  A  kernel store address (write or read).
- neuronAddress  out  A  neuron store address (write or read).
- kernelWrite  out  1  kernel store write enable.
- neuronWrite  out  1  neuron store write enable.
- writeData  out  W  store write data (registered copy of in_data).
- mac_en  out  1  read addresses valid; datapath performs a MAC.
- acc_clear  out  1  with mac_en, marks the first tap of a window.
- win_done  out  1  with mac_en, marks the last tap of a window.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when compute finishes.
- cfg_err  out  1  one-cycle pulse on start with an illegal configuration.

Behaviour:
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- States and transitions:
  - IDLE: in_ready=0. On start, latch the cfg_* inputs.
    - Illegal config (klen==0, stride==0, or klen>nlen): pulse cfg_err next cycle, stay IDLE.
    - Legal config: go to LOAD_K with counter=0.
  - LOAD_K: in_ready=1. Each cycle with in_valid&&in_ready, next cycle has kernelWrite=1, kernelAddress=counter[A-1:0], writeData=in_data; counter increments. After word klen-1 is accepted: counter=0, go to LOAD_N.
  - LOAD_N: same as LOAD_K but drives neuron store signals. After word nlen-1 is accepted: base=0, tap=0, go to COMPUTE.
  - COMPUTE: in_ready=0. Each cycle with hold=0:
    - mac_en=1, kernelAddress=tap, neuronAddress=base+tap.
    - acc_clear=(tap==0); win_done=(tap==klen-1).
    - tap increments. At tap==klen-1: tap=0, base+=stride.
    - If new base+klen>nlen (L+1-bit compare), go to DONE.
    - With hold=1: mac_en, acc_clear and win_done are 0; addresses and counters freeze.
  - DONE: done=1 for one cycle, then IDLE.
- Write strobes are one cycle late relative to the accepting handshake. There are no bubbles: a word can be accepted every cycle.
- Window count = floor((nlen-klen)/stride)+1. This is a consequence of the loop; no divider is used.
- klen==1 gives acc_clear and win_done both high on the same cycle.
- klen==nlen gives exactly one window.
- klen==2^A is legal: the address counter wraps only after the final word.
- start outside IDLE is ignored; latched config is unchanged.
- RST asserted mid-operation returns to IDLE immediately, clears all outputs, and discards partial loads. Store contents are not cleared.
- in_valid while in_ready=0 has no effect.

Decomposition:
- Shared package pe_pkg:
  - State encoding enum: IDLE, LOAD_K, LOAD_N, COMPUTE, DONE.
  - Constants for default A and W.
  - Localparam L.
- One natural sub-module, pe_window_counter: the base/tap counter pair with hold, stride add and end-of-pass compare. It is reused later for 2-D extension.

Test Plan:
- klen=3, nlen=8, stride=1; 11 back-to-back valid words; hold=0 → kernelWrite at addresses 0..2, then neuronWrite at 0..7. Then 18 mac_en cycles, 6 win_done pulses, neuronAddress sequence 0,1,2,1,2,3,…,5,6,7, then done.
- Same config with stride=2 → 3 windows at base 0, 2, 4; 9 mac_en cycles; last neuronAddress is 6.
- klen=1, nlen=4, stride=3 → 2 windows, neuronAddress 0 then 3; acc_clear and win_done both high on each mac_en cycle.
- start with klen=5, nlen=4 (also separately with stride=0) → cfg_err pulse, busy stays 0, no write strobes.
- in_valid toggling every other cycle during load, plus hold=1 for 4 cycles mid-window → write addresses stay contiguous; mac_en low during hold; address sequence resumes unchanged.
- RST asserted during LOAD_N after 2 neuron words → all outputs 0 and busy 0. A new start then runs a clean load from address 0.
